// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the BRAM ring-buffer reader: pointer/depth helpers
// and the output buffer state encoding.
package bram_stream_reader_pkg;

   // Buffer state encoding; the value equals the number of buffered words.
   localparam logic [1:0] B0 = 2'd0;
   localparam logic [1:0] B1 = 2'd1;
   localparam logic [1:0] B2 = 2'd2;

   function automatic int ptr_w(input int pw);
      return pw + 1;
   endfunction

   function automatic int depth(input int pw);
      return 2 ** pw;
   endfunction

endpackage

// File: rtl/bram_stream_reader_skid_buffer.sv
// Two-entry valid/ready output buffer (head + skid) fed by BRAM read data.
// state | meaning
// B0    | empty, M_VALID low
// B1    | head valid
// B2    | head and skid valid
module stream_skid_buffer
   import bram_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 72
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  flush_i,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] push_data_i,
   input  logic                  m_ready_i,
   output logic                  m_valid_o,
   output logic [DATA_WIDTH-1:0] m_data_o,
   output logic [1:0]            count_o
);

   logic [1:0]            state_q, state_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic                  pop;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= B0;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      pop     = (state_q != B0) && m_ready_i;
      case (state_q)
         B0: begin
            if (push_i) begin
               head_d  = push_data_i;
               state_d = B1;
            end
         end
         B1: begin
            case ({push_i, pop})
               2'b10: begin
                  skid_d  = push_data_i;
                  state_d = B2;
               end
               2'b11:   head_d  = push_data_i;
               2'b01:   state_d = B0;
               default: state_d = B1;
            endcase
         end
         B2: begin
            // Credit accounting upstream guarantees no push without a pop here.
            if (pop) begin
               head_d = skid_q;
               if (push_i) skid_d = push_data_i;
               else        state_d = B1;
            end
         end
         default: state_d = B0;
      endcase
      if (flush_i) state_d = B0;
   end

   assign m_valid_o = (state_q != B0);
   assign m_data_o  = head_q;
   assign count_o   = state_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side controller for the BRAM ring buffer: issues reads under a 2-word
// credit and streams data out. Optional ERR_OVERRUN via BRAM_STREAM_READER_OVERRUN_CHECK_EN.
module bram_stream_reader
   import bram_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 72,
   parameter int PTR_WIDTH  = 3
) (
   input  logic                          CLK,
   input  logic                          RESET_N,
   input  logic                          FLUSH,
   input  logic [ptr_w(PTR_WIDTH)-1:0]   WR_PTR,
   output logic [ptr_w(PTR_WIDTH)-1:0]   RD_PTR_OUT,
   output logic                          BRAM_RD_EN,
   output logic [PTR_WIDTH-1:0]          BRAM_RD_PTR,
   input  logic [DATA_WIDTH-1:0]         BRAM_DOUT,
   output logic [DATA_WIDTH-1:0]         M_DOUT,
   output logic                          M_VALID,
   input  logic                          M_READY,
   output logic                          EMPTY,
   output logic [ptr_w(PTR_WIDTH)-1:0]   OCCUPANCY
`ifdef BRAM_STREAM_READER_OVERRUN_CHECK_EN
   ,
   output logic                          ERR_OVERRUN
`endif
);

   localparam int PW = ptr_w(PTR_WIDTH);

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          in_flight_q, in_flight_d;
   logic [1:0]    buf_count;
   logic          avail;
   logic          pop;
   logic [2:0]    occ_after_pop;
   logic          issue;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         rd_ptr_q    <= '0;
         in_flight_q <= 1'b0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         in_flight_q <= in_flight_d;
      end
   end

   // Credit is taken after a same-cycle pop so a streaming consumer sees no bubbles.
   always_comb begin
      avail         = (WR_PTR != rd_ptr_q);
      pop           = M_VALID && M_READY;
      occ_after_pop = {1'b0, buf_count} + {2'b00, in_flight_q} - {2'b00, pop};
      issue         = avail && (occ_after_pop < 3'd2) && !FLUSH;
      rd_ptr_d      = rd_ptr_q;
      in_flight_d   = issue;
      if (FLUSH) begin
         rd_ptr_d    = WR_PTR;
         in_flight_d = 1'b0;
      end else if (issue) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   stream_skid_buffer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .flush_i     (FLUSH),
      .push_i      (in_flight_q && !FLUSH),
      .push_data_i (BRAM_DOUT),
      .m_ready_i   (M_READY),
      .m_valid_o   (M_VALID),
      .m_data_o    (M_DOUT),
      .count_o     (buf_count)
   );

   assign BRAM_RD_EN  = issue;
   assign BRAM_RD_PTR = rd_ptr_q[PTR_WIDTH-1:0];
   assign RD_PTR_OUT  = rd_ptr_q;
   assign OCCUPANCY   = WR_PTR - rd_ptr_q;
   assign EMPTY       = !avail && (buf_count == 2'd0) && !in_flight_q;

`ifdef BRAM_STREAM_READER_OVERRUN_CHECK_EN
   logic err_q, err_d;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) err_q <= 1'b0;
      else          err_q <= err_d;
   end

   always_comb begin
      err_d = err_q || (OCCUPANCY > PW'(depth(PTR_WIDTH)));
      if (FLUSH) err_d = 1'b0;
   end

   assign ERR_OVERRUN = err_q;
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural BRAM and writer.
module tb_bram_stream_reader;

   localparam int DW = 72;
   localparam int PW = 3;

   logic          CLK = 1'b0;
   logic          RESET_N = 1'b0;
   logic          FLUSH = 1'b0;
   logic [PW:0]   WR_PTR = '0;
   logic [PW:0]   RD_PTR_OUT;
   logic          BRAM_RD_EN;
   logic [PW-1:0] BRAM_RD_PTR;
   logic [DW-1:0] BRAM_DOUT = '0;
   logic [DW-1:0] M_DOUT;
   logic          M_VALID;
   logic          M_READY = 1'b0;
   logic          EMPTY;
   logic [PW:0]   OCCUPANCY;
`ifdef BRAM_STREAM_READER_OVERRUN_CHECK_EN
   logic          ERR_OVERRUN;
`endif

   logic [DW-1:0] mem [8];
   logic [DW-1:0] rx_q [$];
   int            rx_cyc [$];
   int            n_chk = 0;
   int            n_pass = 0;
   int            issues = 0;
   int            cyc_n = 0;
   int            n_wr;
   logic [PW:0]   fill;

   bram_stream_reader #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .FLUSH       (FLUSH),
      .WR_PTR      (WR_PTR),
      .RD_PTR_OUT  (RD_PTR_OUT),
      .BRAM_RD_EN  (BRAM_RD_EN),
      .BRAM_RD_PTR (BRAM_RD_PTR),
      .BRAM_DOUT   (BRAM_DOUT),
      .M_DOUT      (M_DOUT),
      .M_VALID     (M_VALID),
      .M_READY     (M_READY),
      .EMPTY       (EMPTY),
      .OCCUPANCY   (OCCUPANCY)
`ifdef BRAM_STREAM_READER_OVERRUN_CHECK_EN
      ,
      .ERR_OVERRUN (ERR_OVERRUN)
`endif
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) if (BRAM_RD_EN) BRAM_DOUT <= mem[BRAM_RD_PTR];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Sample the cycle's handshake/issue just before the edge, then move to the next negedge.
   task automatic cyc();
      #1;
      if (BRAM_RD_EN) issues++;
      if (M_VALID && M_READY) begin
         rx_q.push_back(M_DOUT);
         rx_cyc.push_back(cyc_n);
      end
      cyc_n++;
      @(negedge CLK);
   endtask

   task automatic do_reset();
      RESET_N = 1'b0;
      WR_PTR  = '0;
      FLUSH   = 1'b0;
      M_READY = 1'b0;
      @(negedge CLK);
      RESET_N = 1'b1;
      issues  = 0;
      rx_q.delete();
      rx_cyc.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = '0;

      // Reset values
      @(negedge CLK);
      #1;
      chk("rst_empty", EMPTY, 1);
      chk("rst_mvalid", M_VALID, 0);
      chk("rst_rdptr", RD_PTR_OUT, 0);
      chk("rst_occ", OCCUPANCY, 0);
      chk("rst_rden", BRAM_RD_EN, 0);
      chk("rst_mdout", M_DOUT, 0);
      @(negedge CLK);
      RESET_N = 1'b1;
      repeat (5) cyc();
      chk("idle_issues", issues, 0);
      chk("idle_empty", EMPTY, 1);
      chk("idle_mvalid", M_VALID, 0);

      // Three words, consumer always ready
      for (int i = 0; i < 3; i++) mem[i] = DW'(i + 1);
      WR_PTR  = 4'd3;
      M_READY = 1'b1;
      #1;
      chk("t0_rden", BRAM_RD_EN, 1);
      chk("t0_rdaddr", BRAM_RD_PTR, 0);
      chk("t0_occ", OCCUPANCY, 3);
      cyc();
      chk("t1_mvalid", M_VALID, 0);
      cyc();
      chk("t2_mvalid", M_VALID, 1);
      chk("t2_dout", M_DOUT, 1);
      cyc();
      chk("t3_dout", M_DOUT, 2);
      cyc();
      chk("t4_dout", M_DOUT, 3);
      chk("t4_rdptr", RD_PTR_OUT, 3);
      cyc();
      chk("t5_mvalid", M_VALID, 0);
      chk("t5_empty", EMPTY, 1);

      // Full ring with backpressure, then release
      do_reset();
      for (int i = 0; i < 8; i++) mem[i] = DW'(16 + i);
      WR_PTR  = 4'b1000;
      M_READY = 1'b0;
      repeat (6) cyc();
      chk("bp_issues", issues, 2);
      chk("bp_rdptr", RD_PTR_OUT, 2);
      chk("bp_occ", OCCUPANCY, 6);
      chk("bp_mvalid", M_VALID, 1);
      chk("bp_dout", M_DOUT, 16);
      rx_q.delete();
      rx_cyc.delete();
      M_READY = 1'b1;
      repeat (12) cyc();
      chk("bp_rxcount", rx_q.size(), 8);
      for (int i = 0; i < rx_q.size() && i < 8; i++) chk($sformatf("bp_word%0d", i), rx_q[i], 16 + i);
      if (rx_q.size() == 8) chk("bp_nogap", rx_cyc[7] - rx_cyc[0], 7);

      // Wrap: 20 words through depth 8 with random ready
      do_reset();
      n_wr = 0;
      for (int k = 0; k < 400 && rx_q.size() < 20; k++) begin
         fill = WR_PTR - RD_PTR_OUT;
         if (n_wr < 20 && fill < 4'd8) begin
            mem[WR_PTR[PW-1:0]] = DW'(256 + n_wr);
            WR_PTR = WR_PTR + 4'd1;
            n_wr++;
         end
         M_READY = 1'($urandom_range(0, 1));
         cyc();
      end
      chk("wrap_rxcount", rx_q.size(), 20);
      for (int i = 0; i < rx_q.size() && i < 20; i++) chk($sformatf("wrap_word%0d", i), rx_q[i], 256 + i);
      M_READY = 1'b1;
      repeat (4) cyc();
      chk("wrap_rdptr", RD_PTR_OUT, 4'b0100);
      chk("wrap_empty", EMPTY, 1);
      chk("wrap_extra", rx_q.size(), 20);

      // Flush the cycle after an issue with 5 pending
      do_reset();
      for (int i = 0; i < 5; i++) mem[i] = DW'(512 + i);
      WR_PTR  = 4'd5;
      M_READY = 1'b0;
      cyc();
      FLUSH = 1'b1;
      #1;
      chk("fl_rden", BRAM_RD_EN, 0);
      cyc();
      FLUSH = 1'b0;
      chk("fl_mvalid", M_VALID, 0);
      chk("fl_rdptr", RD_PTR_OUT, 5);
      chk("fl_empty", EMPTY, 1);
      chk("fl_occ", OCCUPANCY, 0);
      repeat (4) cyc();
      chk("fl_late_mvalid", M_VALID, 0);
      chk("fl_issues", issues, 1);

`ifdef BRAM_STREAM_READER_OVERRUN_CHECK_EN
      do_reset();
      chk("ov_rst", ERR_OVERRUN, 0);
      WR_PTR = 4'd9;
      cyc();
      chk("ov_set", ERR_OVERRUN, 1);
      repeat (4) cyc();
      chk("ov_sticky", ERR_OVERRUN, 1);
      FLUSH = 1'b1;
      cyc();
      FLUSH = 1'b0;
      chk("ov_clear", ERR_OVERRUN, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
Read-side controller for the simple dual-port block RAM ring buffer. It compares the writer's wrap-extended write pointer against its own read pointer and issues BRAM reads to cover the 1-cycle registered read latency. Read data is presented as a valid/ready stream through a 2-entry output buffer, giving full throughput. It returns its read pointer to the writer for the full check.

Parameters:
DATA_WIDTH, 72, BRAM word width
PTR_WIDTH, 3, BRAM address width; depth = 2**PTR_WIDTH

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous active-low reset
FLUSH  in  1  synchronous discard of all pending data
WR_PTR  in  PTR_WIDTH+1  writer pointer, MSB = wrap bit; points to the next slot to write
RD_PTR_OUT  out  PTR_WIDTH+1  reader pointer, MSB = wrap bit, returned to the writer
BRAM_RD_EN  out  1  BRAM read enable
BRAM_RD_PTR  out  PTR_WIDTH  BRAM read address
BRAM_DOUT  in  DATA_WIDTH  BRAM registered read data, valid the cycle after BRAM_RD_EN
M_DOUT  out  DATA_WIDTH  stream data
M_VALID  out  1  stream valid
M_READY  in  1  stream ready
EMPTY  out  1  no data in BRAM, in flight, or buffered
OCCUPANCY  out  PTR_WIDTH+1  WR_PTR - rd_ptr (mod 2**(PTR_WIDTH+1)); entries not yet issued

Behaviour:
- Interface: one clock (CLK); reset is asynchronous and active-low (RESET_N).
- Reset values: rd_ptr=0, BRAM_RD_EN=0, BRAM_RD_PTR=0, M_VALID=0, M_DOUT=0, buffer count=0, in_flight=0, EMPTY=1, OCCUPANCY=0.
- avail = (WR_PTR != rd_ptr). Full/empty decode follows the wrap-bit convention: equal pointers = empty; equal index with different MSB = full (8 entries).
- credit = 2 - (buf_count + in_flight). credit never goes negative.
- BRAM_RD_EN is combinational: avail && credit>0 && !FLUSH, where credit is evaluated after any same-cycle M_VALID&&M_READY pop.
- BRAM_RD_PTR = rd_ptr[PTR_WIDTH-1:0].
- On an issue: rd_ptr increments at the same edge (wraps from 2**(PTR_WIDTH+1)-1 to 0), and in_flight<=1.
- Cycle after an issue: BRAM_DOUT is captured into the buffer tail, and in_flight clears unless another read was issued.
- Buffer states:
  - B0: M_VALID=0.
  - B1: head valid.
  - B2: head and skid both valid.
  - Transitions: push only -> up one state; pop only (M_VALID&&M_READY) -> down one state; push and pop in the same cycle -> stay.
  - In B2, a pop shifts skid into head.
- M_DOUT and M_VALID are registered. M_DOUT holds stable while M_VALID && !M_READY.
- Latency: WR_PTR advances in cycle t (buffer empty, nothing in flight) -> BRAM_RD_EN in t -> BRAM_DOUT in t+1 -> M_VALID=1 in t+2.
- Throughput: with M_READY held high, one word per cycle is sustained.
- Backpressure: with M_READY=0, at most 2 words leave the BRAM before reads stall.
- Read-after-write: the writer writes RAM and advances WR_PTR on the same edge, so a read issued after that edge is always safe.
- FLUSH (synchronous, highest priority after reset):
  - rd_ptr<=WR_PTR, buffer -> B0, in_flight<=0, M_VALID<=0.
  - BRAM_RD_EN is forced to 0 in the FLUSH cycle.
  - Data returning the cycle after a FLUSH issue is discarded.
- EMPTY = !avail && buf_count==0 && !in_flight.
- RD_PTR_OUT = rd_ptr (registered). A slot is released to the writer at issue time, not at pop.
- Asynchronous reset mid-transfer drops all buffered and in-flight data; the output stays idle until RESET_N rises.

Optional Feature:
BRAM_STREAM_READER_OVERRUN_CHECK_EN
- With the macro: adds output ERR_OVERRUN (1 bit).
  - Sticky set when computed OCCUPANCY > 2**PTR_WIDTH (writer overran the reader).
  - Cleared only by reset or FLUSH; reset value 0.
- Without the macro: port and logic are absent; overrun is undefined behaviour.

Decomposition:
- Shared package holds:
  - the pointer-width function (PTR_WIDTH+1);
  - the buffer state encoding B0/B1/B2 as localparams;
  - the depth constant 2**PTR_WIDTH.
- One natural sub-module, stream_skid_buffer (2-entry valid/ready buffer, DATA_WIDTH parameter). Issue/credit logic stays in the top module.

Test Plan:
- Reset then idle, WR_PTR=0 -> EMPTY=1, M_VALID=0, BRAM_RD_EN never asserted.
- Writer loads 0x1..0x3 and WR_PTR 0->3 in one cycle, M_READY=1 -> first read in cycle t, M_VALID at t+2, M_DOUT=1,2,3 on consecutive cycles, RD_PTR_OUT=3, EMPTY=1 afterwards.
- Fill 8 words (WR_PTR=4'b1000), M_READY=0 -> exactly 2 reads issued, RD_PTR_OUT=2, OCCUPANCY=6, M_DOUT=word0 held. Then release M_READY -> 8 words out in order, no gaps.
- Wrap: 20 words streamed through depth 8 with random M_READY -> order preserved, RD_PTR_OUT=4'b0100 at end, no duplicate or lost words.
- FLUSH pulsed the cycle after a read issue with 5 pending -> M_VALID=0 next cycle, late BRAM_DOUT discarded, RD_PTR_OUT=WR_PTR, EMPTY=1.
- With overrun check: WR_PTR forced 9 ahead of rd_ptr -> ERR_OVERRUN=1 and stays 1 until FLUSH.
